// File: rtl/riscv_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Accesses have a bounded wait. Define RISCV_MEMARB_RR_EN for round-robin arbitration on contention.
module riscv_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  output logic        i_err,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_size,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, DONE} state_t;

  localparam logic [CNT_W:0] TIMEOUT_L  = (CNT_W+1)'(TIMEOUT);
  localparam bit             TIMEOUT_EN = (TIMEOUT != 0);

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  mem_size_q, mem_size_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_valid_q, i_valid_d;
  logic        d_valid_q, d_valid_d;
  logic        i_err_q, i_err_d;
  logic        d_err_q, d_err_d;
  logic        d_any;
  logic        grant_d;

  assign d_any   = d_read | d_write;
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

`ifdef RISCV_MEMARB_RR_EN
  // last_grant_q: 0 = data was granted last, 1 = fetch was granted last.
  logic last_grant_q, last_grant_d;

  assign grant_d = d_any & ~(i_req & ~last_grant_q);

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b0;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign grant_d = d_any;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    i_err_d     = 1'b0;
    d_err_d     = 1'b0;
`ifdef RISCV_MEMARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_d) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = d_write;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_size_d  = d_funct3;
`ifdef RISCV_MEMARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end else if (i_req) begin
          state_d    = I_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
          mem_size_d = 3'b010;
`ifdef RISCV_MEMARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end
      end
      D_BUSY, I_BUSY: begin
        // A ready arriving on the timeout cycle still completes the access.
        if (mem_ready) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (state_q == I_BUSY) begin
            i_rdata_d = mem_rdata;
            i_valid_d = 1'b1;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end else if (TIMEOUT_EN && (cnt_inc == TIMEOUT_L)) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (state_q == I_BUSY) i_err_d = 1'b1;
          else                   d_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      i_err_q     <= i_err_d;
      d_err_q     <= d_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign i_err     = i_err_q;
  assign d_err     = d_err_q;

  assign stall_if  = i_req & ~i_valid_q & ~i_err_q;
  assign stall_mem = d_any & ~d_valid_q & ~d_err_q;

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the IF-stage instruction fetch and the MEM-stage load/store, which is driven from the EX/MEM pipeline register outputs.
- Grants one requester at a time, sequences the memory handshake and returns read data with a one-cycle valid pulse.
- Generates the stall signals that hold the IF and MEM pipeline stages while their access is outstanding.
- Bounds every access with a timeout so a dead memory port cannot hang the core.

Parameters:
- TIMEOUT, 255: max cycles waiting for mem_ready before abort. 0 disables the timeout.
- CNT_W, 8: timeout counter width. Must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  instruction fetch request, held until i_valid or i_err
- i_addr  in  32  fetch address
- i_rdata  out  32  fetched instruction
- i_valid  out  1  one-cycle fetch completion pulse
- i_err  out  1  one-cycle fetch timeout pulse
- d_read  in  1  load request (mem_read_out of EX/MEM)
- d_write  in  1  store request (mem_write_out of EX/MEM)
- d_addr  in  32  load/store address (alu_result_out)
- d_wdata  in  32  store data (rs2_data_out)
- d_funct3  in  3  access size/sign code, passed through
- d_rdata  out  32  load data
- d_valid  out  1  one-cycle data completion pulse
- d_err  out  1  one-cycle data timeout pulse
- stall_if  out  1  i_req & ~i_valid & ~i_err (combinational)
- stall_mem  out  1  (d_read|d_write) & ~d_valid & ~d_err (combinational)
- mem_req  out  1  memory request, registered
- mem_we  out  1  write enable, registered
- mem_addr  out  32  registered
- mem_wdata  out  32  registered
- mem_size  out  3  registered copy of funct3 (3'b010 for fetches)
- mem_rdata  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion

Behaviour:
- Reset: all registered outputs are 0, i.e. mem_req, mem_we, mem_addr, mem_wdata, mem_size, i_rdata, d_rdata, i_valid, d_valid, i_err and d_err. The FSM goes to IDLE and the counter to 0.
- FSM states: IDLE, D_BUSY, I_BUSY, DONE.
- IDLE:
  - If d_read|d_write, go to D_BUSY and load the mem_* registers from the d_* inputs.
  - Otherwise, if i_req, go to I_BUSY with mem_we=0 and mem_size=3'b010.
  - Data has fixed priority, because the MEM stage is older.
  - mem_req rises on the first cycle in the BUSY state.
- If d_read and d_write are both high, the access is treated as a write (mem_we=1).
- BUSY:
  - mem_* are held stable while mem_req=1.
  - On mem_ready: mem_req drops at the next edge, and the state goes to DONE.
  - On a read, mem_rdata is captured into the granted x_rdata, and x_valid=1 during DONE.
  - On a write, d_valid=1 during DONE and d_rdata is unchanged.
  - Latency: mem_req rises in cycle T+1 for a request first seen in IDLE at T. Best case is mem_ready in T+1 and valid in T+2.
- Timeout:
  - The counter increments each BUSY cycle without mem_ready.
  - When the count reaches TIMEOUT: mem_req drops, x_err is pulsed during DONE, and x_rdata is unchanged.
  - If mem_ready arrives in the same cycle as the timeout, the access completes normally.
- DONE: lasts exactly one cycle and always returns to IDLE. Requesters must drop or change their request by the end of DONE. Back-to-back throughput is one access per 3 cycles minimum.
- x_valid and x_err are never high simultaneously and never both for i and d.
- mem_ready outside BUSY is ignored.
- rst mid-access: go to IDLE immediately. No valid or err pulse; the outstanding memory access is abandoned.

Optional Feature:
- Macro: RISCV_MEMARB_RR_EN.
- Defined: a last_grant flag (reset to D) makes arbitration round-robin when both d and i request in IDLE. The requester not granted last wins.
- Undefined: fixed data priority, and last_grant logic is absent.

Test Plan:
- Lone fetch: i_req=1, i_addr=0x100, mem_ready 2 cycles after mem_req, mem_rdata=0x00500093 -> mem_size=3'b010, mem_we=0, i_rdata=0x00500093, one-cycle i_valid, stall_if low after the pulse.
- Store: d_write=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_funct3=3'b010, mem_ready=1 immediately -> mem_we=1, mem_addr=0x2000, mem_wdata=0xDEADBEEF, d_valid pulses in cycle 3, d_rdata stays 0.
- Contention: d_read and i_req raised in the same cycle, with 1-cycle memory -> data served first, then the fetch. With RISCV_MEMARB_RR_EN defined, a second contention round serves the fetch first.
- Timeout: TIMEOUT=4, d_read=1, mem_ready held 0 -> mem_req high for 4 cycles then low, d_err pulses once, stall_mem clears.
- Reset mid-access: rst asserted while in I_BUSY -> mem_req=0 next cycle, no i_valid, all outputs 0. A new fetch after reset completes normally.
- Both d_read and d_write high -> mem_we=1.
